// File: rtl/io_handshake_unit_if.sv
// io_handshake_unit_if
//   Groups the IN/OUT handshake signals between the instruction decoder and
//   board I/O (master side) and the io_handshake_unit (slave side).
//   Signals:
//     in_req      decoder MO strobe, current instruction is IN
//     out_req     decoder out strobe, current instruction is OUT
//     button      raw confirm key, asynchronous to the clock
//     switches    raw 18-bit switch bank
//     out_data    register-file value to show on OUT
//     flag        1 while an IN/OUT is pending, decoder halts the datapath
//     in_data     {14'b0, latched switches} for the writeback mux
//     display     last OUT value for the 7-segment driver
//     display_vld 1 once any OUT has completed since reset
interface io_handshake_unit_if;
    logic        in_req;
    logic        out_req;
    logic        button;
    logic [17:0] switches;
    logic [31:0] out_data;
    logic        flag;
    logic [31:0] in_data;
    logic [31:0] display;
    logic        display_vld;

    modport master (
        output in_req, out_req, button, switches, out_data,
        input  flag, in_data, display, display_vld
    );

    modport slave (
        input  in_req, out_req, button, switches, out_data,
        output flag, in_data, display, display_vld
    );
endinterface

// File: rtl/io_handshake_unit.sv
// io_handshake_unit
//   Handshake unit for the IN/OUT instructions. While an IN or OUT is decoded
//   it raises flag so the decoder halts the PC, waits for one debounced
//   press-release of the confirm key, latches the switches (IN) or the
//   register value (OUT) on the press, and drops flag for one cycle after
//   the release so the instruction can complete.
//   Ports:
//     clock  system clock, rising-edge
//     reset  asynchronous active-high reset
//     bus    io_handshake_unit_if.slave: requests, raw key/switches, out_data
//            in; flag, in_data, display, display_vld out
module io_handshake_unit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    io_handshake_unit_if.slave    bus
);

    localparam int   CW           = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic RAW_RELEASED = BTN_ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_REL,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   in_data_q, in_data_d;
    logic [31:0]   display_q, display_d;
    logic          vld_q, vld_d;

    logic          key_level;
    logic          level_diff;
    logic          cnt_done;
    logic          press_evt;
    logic          rel_evt;
    logic          req;

    // Key path: two-flop synchronizer, polarity fix, then a debouncer that
    // only accepts a new level after DEBOUNCE_CYCLES consecutive differing
    // samples. The events are taken from the toggle condition itself, so the
    // FSM reacts on the same edge the debounced level flips.
    always_comb begin
        sync1_d    = bus.button;
        sync2_d    = sync1_q;
        key_level  = sync2_q ^ BTN_ACTIVE_LOW;
        level_diff = key_level != deb_q;
        cnt_done   = level_diff && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        press_evt  = cnt_done && !deb_q;
        rel_evt    = cnt_done && deb_q;
        deb_d      = deb_q;
        cnt_d      = '0;
        if (cnt_done) begin
            deb_d = ~deb_q;
        end else if (level_diff) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Handshake FSM. Presses are edge events, so a key already held when the
    // request arrives must be released and pressed again. A simultaneous
    // in_req/out_req is an illegal decode and is handled as IN only.
    always_comb begin
        req       = bus.in_req | bus.out_req;
        state_d   = state_q;
        in_data_d = in_data_q;
        display_d = display_q;
        vld_d     = vld_q;
        case (state_q)
            IDLE: begin
                if (req) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (press_evt) begin
                    state_d = WAIT_REL;
                    if (bus.in_req) begin
                        in_data_d = {14'b0, bus.switches};
                    end else begin
                        display_d = bus.out_data;
                        vld_d     = 1'b1;
                    end
                end
            end
            WAIT_REL: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (rel_evt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset returns the key path to the released level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sync1_q   <= RAW_RELEASED;
            sync2_q   <= RAW_RELEASED;
            deb_q     <= 1'b0;
            cnt_q     <= '0;
            in_data_q <= '0;
            display_q <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            in_data_q <= in_data_d;
            display_q <= display_d;
            vld_q     <= vld_d;
        end
    end

    // flag is combinational from req so the decoder halts in the decode cycle.
    assign bus.flag        = req && (state_q != DONE);
    assign bus.in_data     = in_data_q;
    assign bus.display     = display_q;
    assign bus.display_vld = vld_q;

endmodule

// File: tb/tb_io_handshake_unit.sv
// tb_io_handshake_unit
//   Drives IN/OUT handshakes against io_handshake_unit with a short debounce
//   window. Expected output state per completed transfer is queued when the
//   transfer is issued and compared by a monitor when flag drops.
module tb_io_handshake_unit;
    localparam int DEB = 4;
    localparam int LAT = DEB + 2;

    typedef struct {
        logic [31:0] in_data;
        logic [31:0] display;
        logic        vld;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    io_handshake_unit_if bus();

    io_handshake_unit #(.DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] m_in   = '0;
    logic [31:0] m_disp = '0;
    logic        m_vld  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic setKey(input bit pressed);
        bus.button = pressed ? 1'b0 : 1'b1;
    endtask

    // Completion monitor: a pending request with flag low is the DONE cycle.
    always @(negedge clock) begin
        if (!reset && (bus.in_req || bus.out_req) && !bus.flag) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL unexpected_completion: got completion, expected none");
            end else begin
                mon_e = sb.pop_front();
                checkOutput("done_in_data", bus.in_data, mon_e.in_data);
                checkOutput("done_display", bus.display, mon_e.display);
                checkOutput("done_vld", 32'(bus.display_vld), 32'(mon_e.vld));
            end
        end
    end

    // kind: 0 = IN, 1 = OUT, 2 = both strobes (treated as IN)
    task automatic applyStimulus(input int kind, input logic [17:0] sw, input logic [31:0] od,
                                 input bit bounce, input bit pre_pressed, input int extra_hold,
                                 input bit keep_req);
        logic [31:0] old_in;
        logic [31:0] old_disp;
        int          lat;
        old_in   = m_in;
        old_disp = m_disp;
        if (kind != 1) m_in = {14'b0, sw};
        if (kind == 1) begin
            m_disp = od;
            m_vld  = 1'b1;
        end
        sb.push_back('{m_in, m_disp, m_vld});
        bus.switches = sw;
        bus.out_data = od;
        if (pre_pressed) begin
            setKey(1'b1);
            tick(LAT + 4);
        end
        bus.in_req  = (kind != 1);
        bus.out_req = (kind != 0);
        #1;
        checkOutput("flag_on_decode", 32'(bus.flag), 32'd1);
        if (pre_pressed) begin
            tick(LAT + 4);
            checkOutput("flag_stale_hold", 32'(bus.flag), 32'd1);
            checkOutput("in_data_stale", bus.in_data, old_in);
            setKey(1'b0);
            tick(LAT + 4);
            checkOutput("flag_after_stale_rel", 32'(bus.flag), 32'd1);
        end else begin
            tick(2);
        end
        if (bounce) begin
            for (int b = 0; b < 2; b++) begin
                setKey(1'b1);
                tick(2);
                setKey(1'b0);
                tick(2);
            end
            checkOutput("bounce_no_latch_in", bus.in_data, old_in);
            checkOutput("bounce_no_latch_disp", bus.display, old_disp);
        end
        setKey(1'b1);
        tick(LAT - 1);
        checkOutput("pre_latch_in", bus.in_data, old_in);
        checkOutput("pre_latch_disp", bus.display, old_disp);
        tick(1);
        checkOutput("post_latch_in", bus.in_data, m_in);
        checkOutput("post_latch_disp", bus.display, m_disp);
        checkOutput("post_latch_vld", 32'(bus.display_vld), 32'(m_vld));
        tick(extra_hold);
        bus.switches = 18'($urandom);
        bus.out_data = $urandom;
        setKey(1'b0);
        lat = 0;
        for (int i = 1; i <= 4 * LAT; i++) begin
            tick(1);
            if (!bus.flag) begin
                lat = i;
                break;
            end
        end
        checkOutput("release_latency", 32'(lat), 32'(LAT));
        tick(1);
        checkOutput("flag_back_high", 32'(bus.flag), 32'd1);
        if (!keep_req) begin
            bus.in_req  = 1'b0;
            bus.out_req = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.in_req   = 1'b0;
        bus.out_req  = 1'b0;
        bus.button   = 1'b1;
        bus.switches = '0;
        bus.out_data = '0;
        tick(3);
        checkOutput("reset_in_data", bus.in_data, 32'd0);
        checkOutput("reset_display", bus.display, 32'd0);
        checkOutput("reset_vld", 32'(bus.display_vld), 32'd0);
        checkOutput("reset_flag", 32'(bus.flag), 32'd0);
        reset = 1'b0;
        tick(2);

        // Directed cases: clean IN, OUT then three INs, bounced IN, stale key
        applyStimulus(0, 18'h2A5A5, 32'h0, 1'b0, 1'b0, 4, 1'b0);
        tick(2);
        applyStimulus(1, 18'h0, 32'hDEADBEEF, 1'b0, 1'b0, 4, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 18'(k + 7), 32'h0, 1'b0, 1'b0, 2, k != 2);
        applyStimulus(0, 18'h1F00F, 32'h0, 1'b1, 1'b0, 3, 1'b0);
        applyStimulus(0, 18'h3C3C3, 32'h0, 1'b0, 1'b1, 3, 1'b0);

        // Withdrawn request: key activity afterwards must not latch
        bus.switches = 18'h15555;
        bus.in_req   = 1'b1;
        tick(3);
        checkOutput("withdraw_flag_pending", 32'(bus.flag), 32'd1);
        bus.in_req = 1'b0;
        #1;
        checkOutput("withdraw_flag_drop", 32'(bus.flag), 32'd0);
        setKey(1'b1);
        tick(LAT + 3);
        setKey(1'b0);
        tick(LAT + 3);
        checkOutput("withdraw_no_latch", bus.in_data, m_in);

        // Asynchronous reset in WAIT_REL after an OUT latch
        bus.out_data = 32'hCAFEF00D;
        bus.out_req  = 1'b1;
        tick(2);
        setKey(1'b1);
        tick(LAT + 2);
        checkOutput("abort_latched", bus.display, 32'hCAFEF00D);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_display", bus.display, 32'd0);
        checkOutput("abort_vld", 32'(bus.display_vld), 32'd0);
        checkOutput("abort_in_data", bus.in_data, 32'd0);
        checkOutput("abort_flag", 32'(bus.flag), 32'd1);
        m_in   = '0;
        m_disp = '0;
        m_vld  = 1'b0;
        setKey(1'b0);
        tick(3);
        bus.out_req = 1'b0;
        reset       = 1'b0;
        tick(LAT + 2);

        // Both strobes: IN wins, display untouched
        applyStimulus(2, 18'd3, 32'd5, 1'b0, 1'b0, 2, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 14; t++) begin
            applyStimulus(int'($urandom_range(0, 2)), 18'($urandom), $urandom,
                          1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 5)),
                          (t != 13) && ($urandom_range(0, 1) == 1));
        end

        tick(3);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
